// File: rtl/ws2812_rx.sv
// WS2812 NRZ line receiver: pulse-width bit decode into 24-bit GRB words,
// latch detection, per-frame pixel counting and malformed-traffic flagging.
module ws2812_rx #(
  parameter int unsigned BIT_THRESH   = 30,
  parameter int unsigned MIN_PULSE    = 5,
  parameter int unsigned MAX_PULSE    = 75,
  parameter int unsigned RESET_CYCLES = 2500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [23:0] color,
  output logic        color_valid,
  output logic [4:0]  bit_cnt,
  output logic [15:0] pixel_count,
  output logic        frame_end,
  output logic        error
);

  typedef enum logic [1:0] {
    SYNC,
    LOW,
    HIGH
  } state_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;
  localparam logic [15:0] THRESH  = 16'(BIT_THRESH);
  localparam logic [15:0] MINP    = 16'(MIN_PULSE);
  localparam logic [15:0] MAXP    = 16'(MAX_PULSE);
  localparam logic [15:0] RST_M1  = 16'(RESET_CYCLES - 1);

  state_e      state_q, state_d;
  logic        s1_q, din_s_q, din_d_q;
  logic [15:0] hi_cnt_q, hi_cnt_d;
  logic [15:0] lo_cnt_q, lo_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [23:0] color_q, color_d;
  logic        valid_q, valid_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] pix_q, pix_d;
  logic        fe_q, fe_d;
  logic        err_q, err_d;
  logic        first_q, first_d;

  logic        rise, fall, lo_hit, bit_val;
  logic [23:0] word;

  assign rise    = din_s_q & ~din_d_q;
  assign fall    = ~din_s_q & din_d_q;
  // Single-cycle strobe: the low run is just now reaching RESET_CYCLES.
  assign lo_hit  = ~din_s_q & (lo_cnt_q == RST_M1);
  assign bit_val = (hi_cnt_q >= THRESH);
  assign word    = {shift_q[22:0], bit_val};

  // Pulse-length counters, next-state and output decode.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    color_d   = color_q;
    valid_d   = 1'b0;
    bit_cnt_d = bit_cnt_q;
    pix_d     = pix_q;
    fe_d      = 1'b0;
    err_d     = 1'b0;
    first_d   = first_q;

    if (rise)
      hi_cnt_d = 16'd1;
    else if (din_s_q && hi_cnt_q != CNT_MAX)
      hi_cnt_d = hi_cnt_q + 16'd1;
    else
      hi_cnt_d = hi_cnt_q;

    if (din_s_q)
      lo_cnt_d = '0;
    else if (lo_cnt_q != CNT_MAX)
      lo_cnt_d = lo_cnt_q + 16'd1;
    else
      lo_cnt_d = lo_cnt_q;

    unique case (state_q)
      SYNC: begin
        if (lo_hit)
          state_d = LOW;
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          if (first_q) begin
            pix_d   = '0;
            first_d = 1'b0;
          end
        end else if (lo_hit) begin
          fe_d    = 1'b1;
          first_d = 1'b1;
          if (bit_cnt_q != 5'd0) begin
            err_d     = 1'b1;
            bit_cnt_d = '0;
          end
        end
      end
      HIGH: begin
        if (hi_cnt_q >= MAXP) begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
          state_d   = SYNC;
        end else if (fall) begin
          state_d = LOW;
          if (hi_cnt_q >= MINP) begin
            shift_d = word;
            if (bit_cnt_q == 5'd23) begin
              color_d   = word;
              valid_d   = 1'b1;
              bit_cnt_d = '0;
              if (pix_q != CNT_MAX)
                pix_d = pix_q + 16'd1;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Synchronizer, edge register and all decoder state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SYNC;
      s1_q      <= 1'b0;
      din_s_q   <= 1'b0;
      din_d_q   <= 1'b0;
      hi_cnt_q  <= '0;
      lo_cnt_q  <= '0;
      shift_q   <= '0;
      color_q   <= '0;
      valid_q   <= 1'b0;
      bit_cnt_q <= '0;
      pix_q     <= '0;
      fe_q      <= 1'b0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= din;
      din_s_q   <= s1_q;
      din_d_q   <= din_s_q;
      hi_cnt_q  <= hi_cnt_d;
      lo_cnt_q  <= lo_cnt_d;
      shift_q   <= shift_d;
      color_q   <= color_d;
      valid_q   <= valid_d;
      bit_cnt_q <= bit_cnt_d;
      pix_q     <= pix_d;
      fe_q      <= fe_d;
      err_q     <= err_d;
      first_q   <= first_d;
    end
  end

  assign color       = color_q;
  assign color_valid = valid_q;
  assign bit_cnt     = bit_cnt_q;
  assign pixel_count = pix_q;
  assign frame_end   = fe_q;
  assign error       = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Randomized bench for ws2812_rx: pulse-width words against a queue of
// expected colors plus event counters for latch and error pulses.
module tb_ws2812_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic [23:0] color;
  logic        color_valid;
  logic [4:0]  bit_cnt;
  logic [15:0] pixel_count;
  logic        frame_end;
  logic        error;

  ws2812_rx dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .color(color),
    .color_valid(color_valid),
    .bit_cnt(bit_cnt),
    .pixel_count(pixel_count),
    .frame_end(frame_end),
    .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [23:0] obs_q[$];
  logic [23:0] exp_q[$];
  int fe_n = 0;
  int err_n = 0;
  int both_n = 0;

  always @(negedge clk) begin
    if (color_valid) obs_q.push_back(color);
    if (frame_end) fe_n++;
    if (error) err_n++;
    if (frame_end && error) both_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    @(negedge clk);
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit rnd);
    int h;
    int l;
    if (rnd) begin
      h = b ? int'($urandom_range(60, 30)) : int'($urandom_range(29, 5));
      l = int'($urandom_range(60, 5));
    end else begin
      h = b ? 40 : 20;
      l = 62 - h;
    end
    pulse(h, l);
  endtask

  // Sends the top nbits of w MSB-first; glitch>0 inserts a short pulse
  // after the first 8 bits.
  task automatic send_word(input logic [23:0] w, input bit rnd,
                           input int nbits, input int glitch);
    logic [23:0] v;
    v = w;
    for (int i = 0; i < nbits; i++) begin
      if (glitch > 0 && i == 8) pulse(glitch, 10);
      send_bit(v[23 - i], rnd);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    idle(6);
    check({tag, "_nwords"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check({tag, "_word"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_color"}, color, 0);
    check({tag, "_valid"}, color_valid, 0);
    check({tag, "_bitcnt"}, bit_cnt, 0);
    check({tag, "_pix"}, pixel_count, 0);
    check({tag, "_fe"}, frame_end, 0);
    check({tag, "_err"}, error, 0);
  endtask

  initial begin
    logic [23:0] w;
    int e0;
    int f0;

    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;

    idle(2600);
    check("sync_no_fe", fe_n, 0);

    send_word(24'hFF0000, 0, 24, 0);
    exp_q.push_back(24'hFF0000);
    drain("t1");
    check("t1_color", color, 24'hFF0000);
    check("t1_bitcnt", bit_cnt, 0);
    check("t1_pix", pixel_count, 1);
    idle(2600);
    check("t1_fe", fe_n, 1);

    send_word(24'h123456, 0, 24, 0);
    send_word(24'hABCDEF, 0, 24, 0);
    exp_q.push_back(24'h123456);
    exp_q.push_back(24'hABCDEF);
    idle(2600);
    drain("t2");
    check("t2_fe", fe_n, 2);
    check("t2_pix", pixel_count, 2);
    w = 24'($urandom);
    send_word(w, 1, 24, 0);
    exp_q.push_back(w);
    drain("t2b");
    check("t2b_pix", pixel_count, 1);
    check("t2_err", err_n, 0);

    send_word(24'h00FF00, 0, 24, int'($urandom_range(4, 1)));
    exp_q.push_back(24'h00FF00);
    drain("t3");
    check("t3_color", color, 24'h00FF00);
    check("t3_err", err_n, 0);

    idle(2600);
    f0 = fe_n;
    send_word(24'hA5A5A5, 1, 10, 0);
    check("t4_bitcnt10", bit_cnt, 10);
    idle(2600);
    drain("t4");
    check("t4_both", both_n, 1);
    check("t4_err", err_n, 1);
    check("t4_fe", fe_n, f0 + 1);
    check("t4_bitcnt", bit_cnt, 0);
    check("t4_color", color, 24'h00FF00);

    for (int k = 0; k < 8; k++) begin
      w = 24'($urandom);
      send_word(w, 1, 24, 0);
      exp_q.push_back(w);
    end
    drain("t5");
    check("t5_pix", pixel_count, 8);

    e0 = err_n;
    send_word(24'hFFFFFF, 1, 5, 0);
    pulse(80, 100);
    check("t6_err", err_n, e0 + 1);
    check("t6_bitcnt", bit_cnt, 0);
    send_word(24'h5A5A5A, 1, 24, 0);
    drain("t6_ign");
    check("t6_ign_bitcnt", bit_cnt, 0);
    idle(2600);
    send_word(24'h0000FF, 1, 24, 0);
    exp_q.push_back(24'h0000FF);
    drain("t6");
    check("t6_color", color, 24'h0000FF);

    send_word(24'hC3C3C3, 1, 12, 0);
    rst_n = 1'b0;
    #1;
    check_zero("t7_rst");
    @(negedge clk);
    rst_n = 1'b1;
    send_word(24'h3C3C3C, 1, 24, 0);
    drain("t7_ign");
    check("t7_color0", color, 0);
    idle(2600);
    w = 24'($urandom);
    send_word(w, 1, 24, 0);
    exp_q.push_back(w);
    drain("t7");
    check("t7_pix", pixel_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Single-wire WS2812 NRZ receiver/decoder; the receive end of the LED data line the pixel transmitter drives one color bit at a time.
- Samples the line, measures each high pulse and classifies it as 0 or 1, then rebuilds 24-bit GRB words MSB-first; the first bit received lands in color[23].
- Detects the latch/reset low period, counts pixels per frame and flags malformed traffic.
- Used for loopback self-test of the LED driver and as the input stage of the daisy-chain pass-through.

Parameters:
- BIT_THRESH, 30: high-pulse length in clk cycles at or above which the bit is 1; below it the bit is 0. At 50 MHz, T0H is 20 and T1H is 40.
- MIN_PULSE, 5: high pulses shorter than this are glitches and are discarded.
- MAX_PULSE, 75: a high pulse reaching this length is an error (line stuck high).
- RESET_CYCLES, 2500: a low run of this length is a latch/reset (50 us at 50 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- din  in  1  raw serial line; asynchronous to clk
- color  out  24  last complete word; color[23] is the first bit received
- color_valid  out  1  one-cycle pulse when color updates
- bit_cnt  out  5  bits received in the current word, 0..23
- pixel_count  out  16  words received in the current/last frame; saturates at 0xFFFF
- frame_end  out  1  one-cycle pulse on latch detection
- error  out  1  one-cycle pulse on a malformed word or stuck line

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0; shift register, counters and synchronizer are cleared.
  - State is SYNC. Reset mid-word drops the partial word with no error pulse.
- Input conditioning:
  - din passes through a 2-flop synchronizer to give din_s.
  - din_d is din_s delayed one cycle. Rise = din_s & ~din_d; fall = ~din_s & din_d.
  - All decisions use din_s.
- Counters:
  - hi_cnt and lo_cnt are 16 bits and saturate; lo_cnt clears on a rise.
  - On a rise, hi_cnt loads 1 and then increments while din_s is high.
- SYNC: wait for alignment.
  - lo_cnt counts consecutive low cycles; din_s high clears it.
  - When lo_cnt reaches RESET_CYCLES, go to LOW. No frame_end is issued.
  - Rises are ignored in this state.
- LOW:
  - On a rise, go to HIGH. If this is the first rise since frame_end, pixel_count clears to 0 on the same cycle.
  - When lo_cnt reaches RESET_CYCLES:
    - frame_end pulses.
    - If bit_cnt is not 0, error also pulses and bit_cnt clears.
    - Stay in LOW; frame_end pulses once per low run.
- HIGH:
  - If hi_cnt reaches MAX_PULSE: pulse error, clear bit_cnt, go to SYNC.
  - On a fall with hi_cnt < MIN_PULSE: the pulse is a glitch. Go to LOW; bit_cnt and the shift register are unchanged.
  - On a fall with hi_cnt >= MIN_PULSE: shift (hi_cnt >= BIT_THRESH) into the LSB of the shift register, increment bit_cnt, go to LOW.
  - If bit_cnt was 23 at that fall:
    - color is loaded with the completed 24-bit word on the same edge.
    - color_valid pulses for one cycle.
    - bit_cnt wraps to 0 and pixel_count increments (saturating).
- Latency: color_valid asserts 3 clk after the din falling edge of the 24th pulse (2 synchronizer flops plus edge register).
- Output holding: color holds its value until the next complete word; frame_end and error never alter it.
- Simultaneous events:
  - The fall that completes a word and the start of low counting happen on the same cycle; lo_cnt starts at 1 on that cycle.
  - error and frame_end may pulse in the same cycle.
- Timing independence: no constraint on low time between bits other than RESET_CYCLES; any low run shorter than RESET_CYCLES is inter-bit gap.

Test Plan:
- Hold din low for 2500 cycles after reset, then send 0xFF0000 MSB-first (high 40 for 1s, 20 for 0s, 62-cycle period) -> one color_valid pulse, color=0xFF0000, bit_cnt=0, pixel_count=1.
- Send 0x123456 then 0xABCDEF back to back, then hold low 2500 cycles -> two color_valid pulses with those values in order, then frame_end, pixel_count=2. The next frame's first rise resets pixel_count, which reads 1 after its first word.
- Insert a 3-cycle high glitch between bits 7 and 8 of 0x00FF00 -> color=0x00FF00, no error.
- Send 10 bits, then hold low 2500 cycles -> error and frame_end pulse together, no color_valid, bit_cnt=0.
- Hold din high 80 cycles mid-word -> error at hi_cnt=75, state SYNC. A word sent before 2500 low cycles is ignored; after 2500 low cycles, 0x0000FF decodes correctly.
- Assert rst_n=0 after 12 bits of a word -> all outputs 0 immediately. After release, a word is not decoded until 2500 low cycles have elapsed.
